// File: rtl/discus_mem_arbiter.sv
// discus_mem_arbiter
// Shares one 256x8 synchronous-read data RAM between the discus core data
// port and a host port (debug/loader/DMA). The core cannot stall, so it has
// absolute priority. A host request sits in a one-entry holding register
// and is issued only in a cycle with no core access.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   core_read/core_write       core strobes (both high = write, no response)
//   core_address, core_D       core address / write data
//   core_Q                     core read data, zero outside the response cycle
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata
//                              RAM port (read data valid one cycle after access)
//   host_valid/host_ready      host request handshake
//   host_write/host_address/host_wdata
//                              host request fields
//   host_rvalid/host_rdata     one-cycle host read response, data zero otherwise
//
// Optional feature: define DISCUS_ARB_STATS_EN to add host_stall_count
// (STAT_W bits, saturating), counting cycles a held request is blocked by
// the core.
module discus_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_read,
    input  logic              core_write,
    input  logic [ADDR_W-1:0] core_address,
    input  logic [DATA_W-1:0] core_D,
    output logic [DATA_W-1:0] core_Q,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
`ifdef DISCUS_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] host_stall_count
`endif
);

    if (STAT_W < 1) begin : g_bad_stat_w
        $error("discus_mem_arbiter: STAT_W must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              held_write;
    logic [ADDR_W-1:0] held_addr;
    logic [DATA_W-1:0] held_wdata;
    logic              core_rsp;
    logic              host_rsp;
    logic              core_acc;
    logic              host_accept;
    logic              host_issue;

    always_comb begin
        core_acc    = core_read | core_write;
        host_ready  = (state == EMPTY) && !reset;
        host_accept = host_valid && host_ready;
        // host_ready is low whenever HELD, so accept and issue never coincide
        host_issue  = (state == HELD) && !core_acc && !reset;

        state_nxt = state;
        case (state)
            EMPTY:   if (host_accept) state_nxt = HELD;
            HELD:    if (host_issue)  state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase

        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = core_address;
        ram_wdata = core_D;
        if (!reset) begin
            if (core_acc) begin
                ram_en = 1'b1;
                ram_we = core_write;
            end else if (state == HELD) begin
                ram_en    = 1'b1;
                ram_we    = held_write;
                ram_addr  = held_addr;
                ram_wdata = held_wdata;
            end
        end

        // Responses in flight when reset rises are discarded immediately
        core_Q      = (core_rsp && !reset) ? ram_rdata : '0;
        host_rvalid = host_rsp && !reset;
        host_rdata  = host_rvalid ? ram_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            core_rsp <= 1'b0;
            host_rsp <= 1'b0;
        end else begin
            state    <= state_nxt;
            core_rsp <= core_read & ~core_write;
            host_rsp <= host_issue & ~held_write;
        end
    end

    // Payload needs no reset: it is only used while state is HELD
    always_ff @(posedge clk) begin
        if (host_accept) begin
            held_write <= host_write;
            held_addr  <= host_address;
            held_wdata <= host_wdata;
        end
    end

`ifdef DISCUS_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            host_stall_count <= '0;
        end else if ((state == HELD) && core_acc && (host_stall_count != '1)) begin
            host_stall_count <= host_stall_count + 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_discus_mem_arbiter.sv
module tb_discus_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_read, core_write;
    logic [7:0] core_address, core_D, core_Q;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       host_valid, host_ready, host_write;
    logic [7:0] host_address, host_wdata;
    logic       host_rvalid;
    logic [7:0] host_rdata;
`ifdef DISCUS_ARB_STATS_EN
    logic [3:0] host_stall_count;
`endif

    discus_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STAT_W(4)) dut (
        .clk(clk), .reset(reset),
        .core_read(core_read), .core_write(core_write),
        .core_address(core_address), .core_D(core_D), .core_Q(core_Q),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_write(host_write), .host_address(host_address),
        .host_wdata(host_wdata), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata)
`ifdef DISCUS_ARB_STATS_EN
        , .host_stall_count(host_stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard queues
    typedef struct {
        int unsigned cyc;
        logic [7:0]  d;
    } core_exp_t;
    core_exp_t  cq[$];
    logic [7:0] hq[$];

    task automatic exp_core(input logic [7:0] d);
        core_exp_t e;
        e.cyc = cyc + 1;
        e.d   = d;
        cq.push_back(e);
    endtask

    // Monitor: pops expectations when the DUT presents a response
    always @(negedge clk) begin
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            chk("core_Q_rsp", {24'b0, core_Q}, {24'b0, cq[0].d});
            void'(cq.pop_front());
        end else begin
            chk("core_Q_zero", {24'b0, core_Q}, 32'h0);
        end
        if (host_rvalid) begin
            if (hq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL host_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                chk("host_rdata", {24'b0, host_rdata}, {24'b0, hq.pop_front()});
            end
        end else begin
            chk("host_rdata_zero", {24'b0, host_rdata}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drv(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        core_read = rd; core_write = wr; core_address = a; core_D = d;
    endtask

    task automatic host_drv(input logic v, input logic wr, input logic [7:0] a, input logic [7:0] d);
        host_valid = v; host_write = wr; host_address = a; host_wdata = d;
    endtask

    task automatic chk_ram(input string nm, input logic en, input logic we, input logic [7:0] a, input logic [7:0] d);
        chk({nm, "_en"}, {31'b0, ram_en}, {31'b0, en});
        if (en) begin
            chk({nm, "_we"}, {31'b0, ram_we}, {31'b0, we});
            chk({nm, "_addr"}, {24'b0, ram_addr}, {24'b0, a});
            if (we) chk({nm, "_wdata"}, {24'b0, ram_wdata}, {24'b0, d});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        mem[8'h20] = 8'hC3;
        mem[8'h01] = 8'h91;
        mem[8'h02] = 8'h92;
        mem[8'h03] = 8'h93;
        reset = 1'b1;
        core_drv(0, 0, 8'h00, 8'h00);
        host_drv(0, 0, 8'h00, 8'h00);

        // Reset: core strobe must not reach the RAM
        tick();
        tick();
        core_drv(0, 1, 8'h20, 8'h00);
        #1;
        chk_ram("rst_forced", 0, 0, 8'h00, 8'h00);
        chk("rst_ready", {31'b0, host_ready}, 32'h0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        tick();
        core_drv(0, 0, 8'h00, 8'h00);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {31'b0, host_ready}, 32'h1);
        chk_ram("idle", 0, 0, 8'h00, 8'h00);
`ifdef DISCUS_ARB_STATS_EN
        chk("stall_after_rst", {28'b0, host_stall_count}, 32'h0);
`endif

        // Host read 0x10: accept t, issue t+1, response t+2
        host_drv(1, 0, 8'h10, 8'h00);
        hq.push_back(8'h5A);
        #1;
        chk("accept_ready", {31'b0, host_ready}, 32'h1);
        chk_ram("no_issue_on_accept", 0, 0, 8'h00, 8'h00);
        tick();
        host_drv(0, 0, 8'h00, 8'h00);
        #1;
        chk_ram("host_rd_issue", 1, 0, 8'h10, 8'h00);
        chk("issue_ready", {31'b0, host_ready}, 32'h0);
        tick();
        chk("host_rvalid_t2", {31'b0, host_rvalid}, 32'h1);
        tick();

        // Core read 0x20: data only in the next cycle
        core_drv(1, 0, 8'h20, 8'h00);
        exp_core(8'hC3);
        #1;
        chk_ram("core_rd", 1, 0, 8'h20, 8'h00);
        tick();
        core_drv(0, 0, 8'h00, 8'h00);
        tick();
        tick();

        // Host write 0x33->0x40 held behind three core reads
        host_drv(1, 1, 8'h40, 8'h33);
        tick();
        host_drv(0, 0, 8'h00, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            logic [7:0] a;
            a = 8'(i);
            core_drv(1, 0, a, 8'h00);
            exp_core(8'h90 + a);
            #1;
            chk("held_ready", {31'b0, host_ready}, 32'h0);
            chk_ram("blocked_core_rd", 1, 0, a, 8'h00);
            tick();
        end
        core_drv(0, 0, 8'h00, 8'h00);
        #1;
        chk_ram("host_wr_issue", 1, 1, 8'h40, 8'h33);
`ifdef DISCUS_ARB_STATS_EN
        chk("stall_count_3", {28'b0, host_stall_count}, 32'h3);
`endif
        tick();
        chk("ready_after_wr", {31'b0, host_ready}, 32'h1);
        core_drv(1, 0, 8'h40, 8'h00);
        exp_core(8'h33);
        tick();
        core_drv(0, 0, 8'h00, 8'h00);
        tick();

        // Core write 0x77->0x50 lands before the held host read of 0x50
        host_drv(1, 0, 8'h50, 8'h00);
        hq.push_back(8'h77);
        tick();
        host_drv(0, 0, 8'h00, 8'h00);
        core_drv(0, 1, 8'h50, 8'h77);
        #1;
        chk_ram("core_wr_first", 1, 1, 8'h50, 8'h77);
        tick();
        core_drv(0, 0, 8'h00, 8'h00);
        #1;
        chk_ram("host_rd_after_wr", 1, 0, 8'h50, 8'h00);
        tick();
        tick();

        // Held host write 0xFF->0x10 dropped by reset; core strobe also forced off
        host_drv(1, 1, 8'h10, 8'hFF);
        tick();
        host_drv(0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        core_drv(1, 0, 8'h20, 8'h00);
        #1;
        chk_ram("held_rst", 0, 0, 8'h00, 8'h00);
        tick();
        reset = 1'b0;
        core_drv(0, 0, 8'h00, 8'h00);
        #1;
        chk("ready_after_rst", {31'b0, host_ready}, 32'h1);
        chk_ram("held_dropped", 0, 0, 8'h00, 8'h00);
`ifdef DISCUS_ARB_STATS_EN
        chk("stall_cleared", {28'b0, host_stall_count}, 32'h0);
`endif
        tick();
        core_drv(1, 0, 8'h10, 8'h00);
        exp_core(8'h5A);
        tick();
        core_drv(0, 0, 8'h00, 8'h00);
        tick();

        // In-flight host response discarded by reset
        host_drv(1, 0, 8'h20, 8'h00);
        tick();
        host_drv(0, 0, 8'h00, 8'h00);
        #1;
        chk_ram("inflight_issue", 1, 0, 8'h20, 8'h00);
        tick();
        reset = 1'b1;
        #1;
        chk("inflight_rvalid", {31'b0, host_rvalid}, 32'h0);
        tick();
        reset = 1'b0;
        // In-flight core response discarded by reset
        core_drv(1, 0, 8'h20, 8'h00);
        tick();
        core_drv(0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Starvation / saturation: 20 blocked cycles
        host_drv(1, 0, 8'h20, 8'h00);
        hq.push_back(8'hC3);
        tick();
        host_drv(0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 20; i++) begin
            core_drv(1, 0, 8'h02, 8'h00);
            exp_core(8'h92);
            #1;
            if (i % 5 == 0) chk("starve_ready", {31'b0, host_ready}, 32'h0);
            tick();
        end
        core_drv(0, 0, 8'h00, 8'h00);
        #1;
        chk_ram("starve_issue", 1, 0, 8'h20, 8'h00);
`ifdef DISCUS_ARB_STATS_EN
        chk("stall_saturated", {28'b0, host_stall_count}, 32'hF);
`endif
        tick();
        tick();
        tick();

        chk("core_queue_drained", cq.size(), 32'h0);
        chk("host_queue_drained", hq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/discus_mem_arbiter.md
Name: discus_mem_arbiter

Overview:
- Shares the single 256x8 synchronous-read data RAM between the discus core data port and a host port (debug/loader/DMA) with a valid/ready handshake.
- The core cannot stall, so it has absolute priority. Host requests are parked in a one-entry holding register and issued only in cycles where the core makes no access.
- Gates read data back to the core to zero outside the core's read-response cycle, because the core ORs its memory input into the ALU B operand every cycle.

Parameters:
- ADDR_W, 8, address width of the RAM and both ports.
- DATA_W, 8, data width.
- STAT_W, 16, width of the host stall counter; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- core_read  in  1  core read strobe, one cycle per access.
- core_write  in  1  core write strobe.
- core_address  in  ADDR_W  core access address.
- core_D  in  DATA_W  core write data.
- core_Q  out  DATA_W  read data to core; zero except in a core response cycle.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable; only meaningful with ram_en.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read access.
- host_valid  in  1  host request valid.
- host_ready  out  1  holding register free.
- host_write  in  1  1 = write, 0 = read.
- host_address  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rvalid  out  1  one-cycle pulse: host read data valid.
- host_rdata  out  DATA_W  host read data.

Behaviour:
- Core access, combinational:
  - core_read or core_write high drives ram_en=1, ram_we=core_write, ram_addr=core_address, ram_wdata=core_D in the same cycle.
  - core_read and core_write both high is illegal. It is treated as a write with no read response.
- Core response:
  - Register core_rsp <= core_read & !core_write.
  - core_Q = core_rsp ? ram_rdata : 0, combinational.
  - Read at cycle t gives data on core_Q at t+1 only.
- Host holding register, states EMPTY/HELD:
  - host_ready = (state==EMPTY) and not reset.
  - EMPTY -> HELD when host_valid & host_ready. Capture host_write, host_address and host_wdata.
  - In HELD with no core access this cycle: drive the RAM from the held request, go to EMPTY next cycle, and set host_rsp <= !held_write.
  - In HELD with a core access: the request stays held, the RAM is not driven from the host side, and host_ready stays 0.
  - A request is never accepted and issued in the same cycle. Minimum host read latency: accept at t, issue at t+1, host_rvalid at t+2. Maximum throughput is one host request per 2 cycles.
- Host response:
  - host_rvalid = host_rsp.
  - host_rdata = host_rsp ? ram_rdata : 0.
  - No backpressure on responses; the host must sink them.
- Ordering:
  - Accesses reach the RAM in issue order.
  - A host write issued at t is visible to a core read at t+1 or later.
  - A core write in the cycle the host is blocked lands before the host access.
- Core and host to the same address in the same cycle: the host is deferred (covered by the core-priority rule). No merging.
- Starvation: the host waits indefinitely while the core accesses every cycle. There is no timeout.
- Reset, synchronous, while high:
  - state=EMPTY and a held request is dropped.
  - core_rsp=0, host_rsp=0, host_ready=0.
  - ram_en=0 and ram_we=0, forced even if the core strobes.
- Values after reset: core_Q=0, host_rvalid=0, host_rdata=0, ram_en=0; host_ready=1 from the first cycle after reset deasserts.
- An in-flight response at reset assertion is discarded.

Optional Feature:
- Macro DISCUS_ARB_STATS_EN.
- With the macro defined:
  - Adds output host_stall_count [STAT_W-1:0].
  - Increments in every cycle that state==HELD and a core access blocks issue.
  - Saturates at all-ones and clears on reset.
- Without the macro: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle core; host read addr 0x10 (RAM preloaded 0x5A) accepted at t -> ram_en at t+1 with addr 0x10, host_rvalid=1 and host_rdata=0x5A at t+2, core_Q=0 throughout.
- Core read addr 0x20 (0xC3) at t -> core_Q=0xC3 at t+1 only, 0x00 at t and t+2.
- Host write 0x33->0x40 held while core reads 0x01, 0x02, 0x03 in consecutive cycles:
  - host_ready stays 0 and the write issues in the first idle cycle.
  - With stats enabled, host_stall_count=3.
  - A core read of 0x40 afterwards returns 0x33.
- Core write 0x77->0x50 in the same cycle a held host read of 0x50 is pending -> host read issues next cycle and returns 0x77.
- Host request held, reset asserted one cycle -> no RAM access during reset, no host_rvalid, host_ready=1 the cycle after reset deasserts, RAM contents unchanged.
- Saturation with stats enabled, STAT_W=4: 20 blocked cycles -> host_stall_count=15.
